// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - request/result bundle between the execute-stage control and seq_alu
interface seq_alu_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic [3:0]       ALUCtrl;
    logic [WIDTH-1:0] ALUOut;
    logic             zero_flag;
    logic             carry_flag;
    logic             overflow_flag;
    logic             busy;
    logic             done;

    modport master (
        output start, SrcA, SrcB, ALUCtrl,
        input  ALUOut, zero_flag, carry_flag, overflow_flag, busy, done
    );

    modport slave (
        input  start, SrcA, SrcB, ALUCtrl,
        output ALUOut, zero_flag, carry_flag, overflow_flag, busy, done
    );
endinterface

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multicycle ALU: single-cycle ops plus shift-add MUL and restoring DIVU/REMU
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic      clk,
    input  logic      reset,
    seq_alu_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NOR  = 4'b0101;
    localparam logic [3:0] OP_SLT  = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;
    localparam logic [3:0] OP_DIVU = 4'b1011;
    localparam logic [3:0] OP_REMU = 4'b1100;

    typedef enum logic {S_IDLE, S_ITER} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] hi_q, lo_q, opnd_q;
    logic [3:0]       op_q;
    logic [SHW-1:0]   cnt_q;
    logic [WIDTH-1:0] alu_out_q;
    logic             zero_q, carry_q, ovf_q, done_q;

    logic             is_iter_req, last_iter;
    logic             accept_single, accept_iter, finish_iter, busy_c;

    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   add_full, sub_full;
    logic [WIDTH-1:0] sc_res;
    logic             sc_carry, sc_ovf;

    logic [WIDTH:0]   mul_sum, rem_sh, rem_diff;
    logic [WIDTH-1:0] mul_hi_n, mul_lo_n, div_hi_n, div_lo_n;
    logic             take;
    logic [WIDTH-1:0] it_res;
    logic             it_carry;

    // Divide by zero never enters ITER; it resolves as a single-cycle op.
    assign is_iter_req = (bus.ALUCtrl == OP_MUL) ||
                         (((bus.ALUCtrl == OP_DIVU) || (bus.ALUCtrl == OP_REMU)) && (bus.SrcB != '0));
    assign last_iter   = (cnt_q == SHW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (bus.start && is_iter_req) state_next = S_ITER;
            S_ITER: if (last_iter) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        accept_single = 1'b0;
        accept_iter   = 1'b0;
        finish_iter   = 1'b0;
        busy_c        = 1'b0;
        case (state)
            S_IDLE: begin
                accept_single = bus.start && !is_iter_req;
                accept_iter   = bus.start && is_iter_req;
            end
            S_ITER: begin
                busy_c      = 1'b1;
                finish_iter = last_iter;
            end
            default: ;
        endcase
    end

    assign shamt    = bus.SrcB[SHW-1:0];
    assign add_full = {1'b0, bus.SrcA} + {1'b0, bus.SrcB};
    assign sub_full = {1'b0, bus.SrcA} - {1'b0, bus.SrcB};

    always_comb begin
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        case (bus.ALUCtrl)
            OP_ADD: begin
                sc_res   = add_full[WIDTH-1:0];
                sc_carry = add_full[WIDTH];
                sc_ovf   = (bus.SrcA[MSB] == bus.SrcB[MSB]) && (add_full[MSB] != bus.SrcA[MSB]);
            end
            OP_SUB: begin
                sc_res   = sub_full[WIDTH-1:0];
                sc_carry = !sub_full[WIDTH];
                sc_ovf   = (bus.SrcA[MSB] != bus.SrcB[MSB]) && (sub_full[MSB] != bus.SrcA[MSB]);
            end
            OP_AND:  sc_res = bus.SrcA & bus.SrcB;
            OP_OR:   sc_res = bus.SrcA | bus.SrcB;
            OP_XOR:  sc_res = bus.SrcA ^ bus.SrcB;
            OP_NOR:  sc_res = ~(bus.SrcA | bus.SrcB);
            OP_SLT:  sc_res = WIDTH'($signed(bus.SrcA) < $signed(bus.SrcB));
            OP_SLL:  sc_res = bus.SrcA << shamt;
            OP_SRL:  sc_res = bus.SrcA >> shamt;
            OP_SRA:  sc_res = $unsigned($signed(bus.SrcA) >>> shamt);
            OP_DIVU: sc_res = '1;
            OP_REMU: sc_res = bus.SrcA;
            default: sc_res = '0;
        endcase
    end

    // hi:lo is the 2*WIDTH product register for MUL, remainder:quotient for DIVU/REMU.
    assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_hi_n = mul_sum[WIDTH:1];
    assign mul_lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};

    assign rem_sh   = {hi_q, lo_q[WIDTH-1]};
    assign rem_diff = rem_sh - {1'b0, opnd_q};
    assign take     = !rem_diff[WIDTH];
    assign div_hi_n = take ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign div_lo_n = {lo_q[WIDTH-2:0], take};

    always_comb begin
        it_res   = '0;
        it_carry = 1'b0;
        case (op_q)
            OP_MUL: begin
                it_res   = mul_lo_n;
                it_carry = |mul_hi_n;
            end
            OP_DIVU: it_res = div_lo_n;
            OP_REMU: it_res = div_hi_n;
            default: it_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_out_q <= '0;
            zero_q    <= 1'b1;
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            opnd_q    <= '0;
            op_q      <= '0;
            cnt_q     <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept_single) begin
                alu_out_q <= sc_res;
                zero_q    <= (sc_res == '0);
                carry_q   <= sc_carry;
                ovf_q     <= sc_ovf;
                done_q    <= 1'b1;
            end
            if (accept_iter) begin
                op_q   <= bus.ALUCtrl;
                opnd_q <= bus.SrcB;
                lo_q   <= bus.SrcA;
                hi_q   <= '0;
                cnt_q  <= '0;
            end
            if (busy_c) begin
                hi_q  <= (op_q == OP_MUL) ? mul_hi_n : div_hi_n;
                lo_q  <= (op_q == OP_MUL) ? mul_lo_n : div_lo_n;
                cnt_q <= cnt_q + SHW'(1);
            end
            if (finish_iter) begin
                alu_out_q <= it_res;
                zero_q    <= (it_res == '0);
                carry_q   <= it_carry;
                ovf_q     <= 1'b0;
                done_q    <= 1'b1;
            end
        end
    end

    assign bus.ALUOut        = alu_out_q;
    assign bus.zero_flag     = zero_q;
    assign bus.carry_flag    = carry_q;
    assign bus.overflow_flag = ovf_q;
    assign bus.busy          = busy_c;
    assign bus.done          = done_q;
endmodule
